// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM, load-data return, MEM->WB and forwarding signals of the memory stage
interface mem_stage_if;
    logic        to_mem_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_alu_result;
    logic [2:0]  ex_ld_op;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic        wb_allow_in;
    logic        mem_allow_in;
    logic        mem_valid;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic [3:0]  mem_rf_we;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_rf_wdata;
    logic [3:0]  mem_fwd_we;
    logic [4:0]  mem_fwd_waddr;
    logic [31:0] mem_fwd_wdata;
    logic        mem_fwd_stall;

    modport slave (
        input  to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result, ex_ld_op,
        input  data_sram_rdata, data_sram_data_ok, wb_allow_in,
        output mem_allow_in, mem_valid, mem_to_wb_valid,
        output mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
        output mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, mem_fwd_stall
    );

    modport master (
        output to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result, ex_ld_op,
        output data_sram_rdata, data_sram_data_ok, wb_allow_in,
        input  mem_allow_in, mem_valid, mem_to_wb_valid,
        input  mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
        input  mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, mem_fwd_stall
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with load wait/hold FSM and load alignment; MEM_STAGE_FWD_EN enables the ID forwarding bus
module mem_stage (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic        valid_r, allow_in, ready_go, accept, accept_load, is_load;
    logic [31:0] pc_r, alu_r, buf_r, ld_data, ld_wdata, rf_wdata;
    logic [3:0]  we_r, rf_we;
    logic [4:0]  waddr_r;
    logic [2:0]  ld_op_r;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_load     = ld_op_r != 3'b000;
    assign allow_in    = !valid_r | (ready_go & bus.wb_allow_in);
    assign accept      = bus.to_mem_valid & allow_in;
    assign accept_load = accept & (bus.ex_ld_op != 3'b000);

    // FSM state register; reset drops any outstanding load
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: a new load may be accepted in the same cycle the current one retires
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept_load ? S_WAIT : S_IDLE;
            S_WAIT:  state_nxt = !bus.data_sram_data_ok ? S_WAIT :
                                 !bus.wb_allow_in ? S_HOLD :
                                 accept_load ? S_WAIT : S_IDLE;
            S_HOLD:  state_nxt = !bus.wb_allow_in ? S_HOLD :
                                 accept_load ? S_WAIT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: readiness and which copy of the load data is live
    always_comb begin
        ready_go = state == S_IDLE ? !is_load :
                   state == S_WAIT ? bus.data_sram_data_ok :
                   state == S_HOLD;
        ld_data  = state == S_HOLD ? buf_r : bus.data_sram_rdata;
    end

    // stage valid bit follows EX whenever this stage can take a new instruction
    always_ff @(posedge clk) begin
        if (reset)         valid_r <= 1'b0;
        else if (allow_in) valid_r <= bus.to_mem_valid;
    end

    // pipeline registers capture only on an actual accept
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= '0;
            we_r    <= '0;
            waddr_r <= '0;
            alu_r   <= '0;
            ld_op_r <= '0;
        end else if (accept) begin
            pc_r    <= bus.ex_pc;
            we_r    <= bus.ex_rf_we;
            waddr_r <= bus.ex_rf_waddr;
            alu_r   <= bus.ex_alu_result;
            ld_op_r <= bus.ex_ld_op;
        end
    end

    // load data that arrives while WB is blocked is parked until WB accepts
    always_ff @(posedge clk) begin
        if (reset)                                                          buf_r <= '0;
        else if (state == S_WAIT && bus.data_sram_data_ok && !bus.wb_allow_in) buf_r <= bus.data_sram_rdata;
    end

    // byte/half extraction by address offset, then sign or zero extension
    always_comb begin
        ld_byte  = 8'(ld_data >> {alu_r[1:0], 3'b000});
        ld_half  = 16'(ld_data >> {alu_r[1], 4'b0000});
        ld_wdata = ld_op_r == 3'b001 ? {{24{ld_byte[7]}}, ld_byte} :
                   ld_op_r == 3'b101 ? {24'b0, ld_byte} :
                   ld_op_r == 3'b010 ? {{16{ld_half[15]}}, ld_half} :
                   ld_op_r == 3'b110 ? {16'b0, ld_half} : ld_data;
        rf_wdata = is_load ? ld_wdata : alu_r;
        rf_we    = valid_r ? we_r : 4'b0;
    end

    assign bus.mem_allow_in    = allow_in;
    assign bus.mem_valid       = valid_r;
    assign bus.mem_to_wb_valid = valid_r & ready_go;
    assign bus.mem_pc          = pc_r;
    assign bus.mem_rf_we       = rf_we;
    assign bus.mem_rf_waddr    = waddr_r;
    assign bus.mem_rf_wdata    = rf_wdata;

`ifdef MEM_STAGE_FWD_EN
    assign bus.mem_fwd_we    = rf_we;
    assign bus.mem_fwd_waddr = waddr_r;
    assign bus.mem_fwd_wdata = rf_wdata;
    assign bus.mem_fwd_stall = valid_r & is_load & !ready_go;
`else
    assign bus.mem_fwd_we    = 4'b0;
    assign bus.mem_fwd_waddr = 5'b0;
    assign bus.mem_fwd_wdata = 32'b0;
    assign bus.mem_fwd_stall = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of handshake, load alignment, wait/hold FSM, reset and forwarding bus
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

`ifdef MEM_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    mem_stage_if bus ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [2:0] ld);
        bus.to_mem_valid  = v;
        bus.ex_pc         = pc;
        bus.ex_rf_we      = 4'hF;
        bus.ex_rf_waddr   = wa;
        bus.ex_alu_result = alu;
        bus.ex_ld_op      = ld;
    endtask

    task automatic sram(input logic ok, input logic [31:0] d);
        bus.data_sram_data_ok = ok;
        bus.data_sram_rdata   = d;
    endtask

    initial begin
        reset = 1'b1;
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        sram(1'b0, 32'h0);
        bus.wb_allow_in = 1'b1;
        repeat (2) tick();
        #1;
        chk("rst_valid", bus.mem_valid, 0);
        chk("rst_to_wb", bus.mem_to_wb_valid, 0);
        chk("rst_rf_we", bus.mem_rf_we, 0);
        chk("rst_pc", bus.mem_pc, 0);
        chk("rst_allow", bus.mem_allow_in, 1);
        chk("rst_fwd_we", bus.mem_fwd_we, 0);
        chk("rst_fwd_stall", bus.mem_fwd_stall, 0);
        reset = 1'b0;

        ex(1'b1, 32'h0000_0100, 5'd5, 32'h1234_5678, 3'b000);
        #1;
        chk("alu_allow", bus.mem_allow_in, 1);
        tick();
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        #1;
        chk("alu_to_wb", bus.mem_to_wb_valid, 1);
        chk("alu_wdata", bus.mem_rf_wdata, 32'h1234_5678);
        chk("alu_waddr", bus.mem_rf_waddr, 5);
        chk("alu_rf_we", bus.mem_rf_we, 4'hF);
        chk("alu_pc", bus.mem_pc, 32'h0000_0100);
        chk("alu_fwd_we", bus.mem_fwd_we, FWD ? 4'hF : 4'h0);
        chk("alu_fwd_wdata", bus.mem_fwd_wdata, FWD ? 32'h1234_5678 : 32'h0);
        chk("alu_fwd_waddr", bus.mem_fwd_waddr, FWD ? 5 : 0);
        tick();
        #1;
        chk("alu_drain_valid", bus.mem_valid, 0);
        chk("alu_drain_rf_we", bus.mem_rf_we, 0);

        ex(1'b1, 32'h0000_0200, 5'd7, 32'h0000_1003, 3'b001);
        tick();
        ex(1'b1, 32'h0000_0204, 5'd8, 32'h0000_2003, 3'b101);
        sram(1'b1, 32'h80AB_CDEF);
        #1;
        chk("ldb_to_wb", bus.mem_to_wb_valid, 1);
        chk("ldb_wdata", bus.mem_rf_wdata, 32'hFFFF_FF80);
        chk("ldb_allow", bus.mem_allow_in, 1);
        tick();
        ex(1'b1, 32'h0000_0208, 5'd9, 32'h0000_3002, 3'b010);
        #1;
        chk("ldbu_to_wb", bus.mem_to_wb_valid, 1);
        chk("ldbu_wdata", bus.mem_rf_wdata, 32'h0000_0080);
        chk("ldbu_waddr", bus.mem_rf_waddr, 8);
        tick();
        ex(1'b1, 32'h0000_020C, 5'd10, 32'h0000_3006, 3'b110);
        #1;
        chk("ldh_wdata", bus.mem_rf_wdata, 32'hFFFF_80AB);
        chk("ldh_allow", bus.mem_allow_in, 1);
        tick();
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        #1;
        chk("ldhu_wdata", bus.mem_rf_wdata, 32'h0000_80AB);
        chk("ldhu_to_wb", bus.mem_to_wb_valid, 1);
        tick();
        sram(1'b0, 32'h0);
        #1;
        chk("chain_drain_valid", bus.mem_valid, 0);

        ex(1'b1, 32'h0000_0300, 5'd11, 32'h0000_4000, 3'b011);
        tick();
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_allow", bus.mem_allow_in, 0);
            chk("stall_to_wb", bus.mem_to_wb_valid, 0);
            chk("stall_fwd_stall", bus.mem_fwd_stall, FWD ? 1 : 0);
            chk("stall_fwd_we", bus.mem_fwd_we, FWD ? 4'hF : 4'h0);
            chk("stall_fwd_waddr", bus.mem_fwd_waddr, FWD ? 11 : 0);
            tick();
        end
        sram(1'b1, 32'h1122_3344);
        #1;
        chk("late_to_wb", bus.mem_to_wb_valid, 1);
        chk("late_wdata", bus.mem_rf_wdata, 32'h1122_3344);
        chk("late_allow", bus.mem_allow_in, 1);
        chk("late_fwd_stall", bus.mem_fwd_stall, 0);
        tick();
        sram(1'b0, 32'h0);
        #1;
        chk("late_drain_to_wb", bus.mem_to_wb_valid, 0);

        ex(1'b1, 32'h0000_0400, 5'd12, 32'h0000_5000, 3'b011);
        tick();
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        sram(1'b1, 32'hDEAD_BEEF);
        bus.wb_allow_in = 1'b0;
        #1;
        chk("hold_ok_allow", bus.mem_allow_in, 0);
        chk("hold_ok_wdata", bus.mem_rf_wdata, 32'hDEAD_BEEF);
        tick();
        sram(1'b0, 32'h0BAD_F00D);
        #1;
        chk("hold_to_wb", bus.mem_to_wb_valid, 1);
        chk("hold_wdata", bus.mem_rf_wdata, 32'hDEAD_BEEF);
        chk("hold_allow", bus.mem_allow_in, 0);
        tick();
        bus.wb_allow_in = 1'b1;
        sram(1'b1, 32'h0BAD_F00D);
        #1;
        chk("hold_rel_wdata", bus.mem_rf_wdata, 32'hDEAD_BEEF);
        chk("hold_rel_allow", bus.mem_allow_in, 1);
        tick();
        sram(1'b0, 32'h0);
        #1;
        chk("hold_drain_valid", bus.mem_valid, 0);
        chk("hold_drain_to_wb", bus.mem_to_wb_valid, 0);

        ex(1'b1, 32'h0000_0500, 5'd13, 32'h0000_6000, 3'b011);
        tick();
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        #1;
        chk("rstw_wait_to_wb", bus.mem_to_wb_valid, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sram(1'b1, 32'hCAFE_F00D);
        #1;
        chk("rstw_valid", bus.mem_valid, 0);
        chk("rstw_to_wb", bus.mem_to_wb_valid, 0);
        chk("rstw_rf_we", bus.mem_rf_we, 0);
        chk("rstw_allow", bus.mem_allow_in, 1);
        tick();
        sram(1'b0, 32'h0);
        ex(1'b1, 32'h0000_0600, 5'd3, 32'h0000_ABCD, 3'b000);
        #1;
        chk("rstw_after_valid", bus.mem_valid, 0);
        tick();
        ex(1'b0, 32'h0, 5'd0, 32'h0, 3'b000);
        #1;
        chk("rstw_idle_to_wb", bus.mem_to_wb_valid, 1);
        chk("rstw_idle_wdata", bus.mem_rf_wdata, 32'h0000_ABCD);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 to_mem_valid  in  1  EX stage presents a valid instruction.
REQ-004 ex_pc  in  32  instruction PC from EX.
REQ-005 ex_rf_we  in  4  register-file byte write enables from EX.
REQ-006 ex_rf_waddr  in  5  destination register from EX.
REQ-007 ex_alu_result  in  32  ALU result, or load address for loads.
REQ-008 ex_ld_op  in  3  load type: 000 none, 001 ld.b, 010 ld.h, 011 ld.w, 101 ld.bu, 110 ld.hu.
REQ-009 data_sram_rdata  in  32  load data return.
REQ-010 data_sram_data_ok  in  1  one-cycle pulse: rdata valid for the outstanding load.
REQ-011 wb_allow_in  in  1  WB accepts an instruction this cycle.
REQ-012 mem_allow_in  out  1  MEM accepts from EX this cycle.
REQ-013 mem_valid  out  1  MEM holds a valid instruction (register).
REQ-014 mem_to_wb_valid  out  1  mem_valid AND mem_ready_go.
REQ-015 mem_pc / mem_rf_we / mem_rf_waddr / mem_rf_wdata  out  32/4/5/32  bus to WB; mem_rf_we forced 0 when !mem_valid.
REQ-016 mem_fwd_we / mem_fwd_waddr / mem_fwd_wdata / mem_fwd_stall  out  4/5/32/1  forwarding bus to ID.

Function
REQ-017 Handshake: mem_allow_in = !mem_valid | (mem_ready_go & wb_allow_in); mem_valid <= to_mem_valid when mem_allow_in.
REQ-018 Pipeline registers (pc, rf_we, rf_waddr, alu_result, ld_op) load from EX only when to_mem_valid & mem_allow_in; otherwise hold.
REQ-019 FSM states: IDLE (no outstanding load), WAIT (load outstanding, no data), HOLD (load data buffered, awaiting WB).
REQ-020 IDLE->WAIT on accepting a load (ld_op != 000); IDLE->IDLE on accepting a non-load or no accept.
REQ-021 WAIT: on data_ok with wb_allow_in -> IDLE, or WAIT if a new load accepted same cycle; on data_ok without wb_allow_in -> HOLD, rdata captured in 32-bit buffer.
REQ-022 HOLD -> IDLE/WAIT (per REQ-020) when wb_allow_in; data_ok in IDLE or HOLD ignored.
REQ-023 mem_ready_go = 1 in IDLE with non-load, 1 in WAIT only in the data_ok cycle, 1 in HOLD; else 0.
REQ-024 Load data source: data_sram_rdata in WAIT data_ok cycle, buffer in HOLD.
REQ-025 Alignment by alu_result[1:0]: byte = data >> (8*addr[1:0]); half = data >> (16*addr[1]); ld.b/ld.h sign-extend, ld.bu/ld.hu zero-extend, ld.w unshifted.
REQ-026 mem_rf_wdata = aligned load data for loads, alu_result otherwise.
REQ-027 Latency: non-load passes to WB the cycle after acceptance if wb_allow_in; load passes in data_ok cycle (min 1 cycle after acceptance).
REQ-028 Back-to-back accepts with no bubble when WB always allows and every data_ok arrives the cycle after acceptance.

Reset
REQ-029 reset: mem_valid=0, FSM=IDLE, buffer=0, mem_rf_we=0, mem_to_wb_valid=0, mem_fwd_we=0, mem_fwd_stall=0; pipeline data registers 0.
REQ-030 reset during WAIT/HOLD discards the load; data_ok asserted during reset or in the cycle after ignored.

Configuration
REQ-031 Macro MEM_STAGE_FWD_EN defined: mem_fwd_we = mem_rf_we (gated by mem_valid), mem_fwd_waddr = mem_rf_waddr, mem_fwd_wdata = mem_rf_wdata, mem_fwd_stall = mem_valid & load & !mem_ready_go.
REQ-032 Macro undefined: all mem_fwd_* outputs constant 0; ports remain present.

Verification
REQ-033 ALU op 0x1234_5678 to r5, wb_allow_in=1 -> next cycle mem_to_wb_valid=1, wdata=0x1234_5678, waddr=5, rf_we=4'hF.
REQ-034 ld.b addr[1:0]=3, rdata=0x80AB_CDEF -> wdata 0xFFFF_FF80; ld.bu same -> 0x0000_0080; ld.h addr[1]=1 -> 0xFFFF_80AB.
REQ-035 Load, data_ok 3 cycles later -> mem_allow_in=0 and mem_to_wb_valid=0 for 2 cycles, then 1-cycle pass; with MEM_STAGE_FWD_EN, mem_fwd_stall=1 in those 2 cycles.
REQ-036 Load, data_ok with wb_allow_in=0 for 2 cycles -> HOLD, buffered 0xDEAD_BEEF delivered when wb_allow_in=1 despite rdata changing.
REQ-037 Reset asserted in WAIT, data_ok pulsed the cycle after release -> mem_valid=0, FSM=IDLE, nothing to WB.
REQ-038 Macro undefined, load stalled -> all mem_fwd_* read 0 every cycle.
